// File: rtl/fpu_issue_sequencer.sv
// Issue/latency/writeback controller for the shared multi-cycle FPU adder.
// Accepts one add.s/sub.s at a time, pulses the FPU start, counts the fixed
// FPU latency and owns the float register file write port for the single
// writeback cycle. Stall covers RAW on the in-flight destination, a second
// issue while executing, and an LWC1 colliding with the writeback cycle.
//
// Handshake: the decoder presents issue_valid (plus operands) and must hold
// all decode inputs stable while stall=1; an issue is taken in exactly the
// cycle fpu_start=1, which never coincides with stall=1.
module fpu_issue_sequencer #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic       issue_sub,
    input  logic [4:0] issue_fd,
    input  logic       use_fs,
    input  logic [4:0] src_fs,
    input  logic       use_ft,
    input  logic [4:0] src_ft,
    input  logic       lwc1_we,
    output logic       stall,
    output logic       fpu_start,
    output logic       fpu_sub,
    output logic       fpu_wb_en,
    output logic [4:0] fpu_wb_addr,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_fd;
    logic             r_op;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_busy;
    logic             w_hazard;
    logic             w_stall;
    logic             w_accept;

    // Busy, hazard, stall and accept terms shared by next-state and outputs.
    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_hazard = w_busy & ((use_fs & (src_fs == r_fd)) |
                             (use_ft & (src_ft == r_fd)));
        w_stall  = w_hazard |
                   (issue_valid & (r_state == S_EXEC)) |
                   (lwc1_we & (r_state == S_WB));
        w_accept = issue_valid & ~w_stall &
                   ((r_state == S_IDLE) | (r_state == S_WB));
    end

    // Next-state and latency counter; WB can chain straight into EXEC.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_EXEC;
                    w_next_cnt   = LAT_M1;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            S_WB: begin
                if (w_accept) begin
                    w_next_state = S_EXEC;
                    w_next_cnt   = LAT_M1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, counter and captured op registers; reset abandons any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fd    <= '0;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_fd <= issue_fd;
                r_op <= issue_sub;
            end
        end
    end

    // Outputs; write address is forced to zero outside the writeback cycle.
    always_comb begin
        stall       = w_stall;
        fpu_start   = w_accept;
        fpu_sub     = w_accept ? issue_sub : r_op;
        fpu_wb_en   = (r_state == S_WB);
        fpu_wb_addr = (r_state == S_WB) ? r_fd : 5'd0;
        busy        = w_busy;
        dbg_state   = r_state;
    end

endmodule
